// File: rtl/uart_rx_framer_pkg.sv
// uart_rx_framer_pkg
//   Shared definitions for the UART receive framer: FSM state encoding,
//   frame_err code values, payload buffer depth and a small state helper.
//   No ports (package).
package uart_rx_framer_pkg;

  // Framer FSM states. HUNT is the reset state.
  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // frame_err codes
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Payload buffer depth in bytes (upper bound on MAX_LEN).
  localparam int BUF_BYTES = 8;

  // States that sit mid-frame waiting for a byte; the inter-byte
  // timeout only runs in these.
  function automatic logic is_waiting(state_t s);
    return (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/uart_rx_framer_if.sv
// uart_rx_framer_if
//   Bundles the UART receive FIFO handshake and the frame result outputs.
//   Signals:
//     rx_empty    FIFO empty flag (into framer)
//     r_data[7:0] FIFO head byte, valid while rx_empty=0 (into framer)
//     rd_uart     one-cycle FIFO pop strobe (from framer)
//     frame_valid one-cycle good-frame pulse (from framer)
//     frame_len   payload length of last good frame (from framer)
//     frame_data  payload of last good frame, byte 0 in [7:0] (from framer)
//     frame_err   one-cycle error code (from framer)
//   Modports: master = framer side, slave = FIFO/consumer side.
interface uart_rx_framer_if;
  logic        rx_empty;
  logic [7:0]  r_data;
  logic        rd_uart;
  logic        frame_valid;
  logic [3:0]  frame_len;
  logic [63:0] frame_data;
  logic [1:0]  frame_err;

  modport master (
    input  rx_empty, r_data,
    output rd_uart, frame_valid, frame_len, frame_data, frame_err
  );

  modport slave (
    output rx_empty, r_data,
    input  rd_uart, frame_valid, frame_len, frame_data, frame_err
  );
endinterface

// File: rtl/uart_timeout_ctr.sv
// uart_timeout_ctr
//   Idle-cycle counter for the inter-byte timeout.
//   Ports:
//     clk     system clock
//     reset   asynchronous active-high reset
//     clear   zero the count (wins over enable)
//     enable  count this cycle
//     expired high in the enabled cycle that brings the count to TIMEOUT
module uart_timeout_ctr #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  // Wide enough to hold TIMEOUT itself so the count never wraps early.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // Fires on the TIMEOUT-th consecutive idle cycle.
  assign expired = enable && !clear && (count_reg == LAST);

endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer
//   Pulls bytes from a UART receive FIFO and assembles frames of the form
//   SOF, LEN, LEN payload bytes, CHK (CHK = XOR of LEN and payload).
//   Good frames raise frame_valid for one cycle and update frame_len /
//   frame_data; bad frames raise a one-cycle frame_err code instead.
//   Ports:
//     clk    system clock
//     reset  asynchronous active-high reset
//     bus    uart_rx_framer_if.master (FIFO handshake + frame results)
module uart_rx_framer
  import uart_rx_framer_pkg::*;
#(
  parameter logic [7:0] SOF     = 8'hA5,
  parameter int         MAX_LEN = 8,
  parameter int         TIMEOUT = 50000
) (
  input logic              clk,
  input logic              reset,
  uart_rx_framer_if.master bus
);

  state_t      state_reg, state_next;
  logic [3:0]  len_reg;
  logic [2:0]  count_reg;
  logic [7:0]  chk_reg;
  logic [63:0] buf_flat;

  logic        frame_valid_reg;
  logic [1:0]  frame_err_reg, err_next;
  logic [3:0]  frame_len_reg;
  logic [63:0] frame_data_reg;

  logic pop, len_ok, last_payload;
  logic load_len, store_byte, frame_done;
  logic to_clear, to_enable, to_expired;

  // Every state except DONE accepts a byte whenever one is available.
  // Gated by reset so no pop can leak out while reset is held.
  assign pop          = (state_reg != ST_DONE) && !bus.rx_empty && !reset;
  assign len_ok       = (bus.r_data != 8'd0) && (bus.r_data <= 8'(MAX_LEN));
  assign last_payload = ({1'b0, count_reg} == (len_reg - 4'd1));

  assign to_clear  = pop || (state_reg == ST_HUNT);
  assign to_enable = is_waiting(state_reg) && !pop;

  uart_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (to_clear),
    .enable (to_enable),
    .expired(to_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_HUNT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    err_next   = ERR_NONE;
    load_len   = 1'b0;
    store_byte = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      ST_HUNT: begin
        if (pop && (bus.r_data == SOF)) begin
          state_next = ST_LEN;
        end
      end
      ST_LEN: begin
        if (pop) begin
          if (len_ok) begin
            load_len   = 1'b1;
            state_next = ST_PAYLOAD;
          end else begin
            err_next   = ERR_LEN;
            state_next = ST_HUNT;
          end
        end else if (to_expired) begin
          err_next   = ERR_TIMEOUT;
          state_next = ST_HUNT;
        end
      end
      ST_PAYLOAD: begin
        // SOF values here are ordinary payload; no resync mid-frame.
        if (pop) begin
          store_byte = 1'b1;
          if (last_payload) begin
            state_next = ST_CHK;
          end
        end else if (to_expired) begin
          err_next   = ERR_TIMEOUT;
          state_next = ST_HUNT;
        end
      end
      ST_CHK: begin
        if (pop) begin
          if (bus.r_data == chk_reg) begin
            frame_done = 1'b1;
            state_next = ST_DONE;
          end else begin
            err_next   = ERR_CHK;
            state_next = ST_HUNT;
          end
        end else if (to_expired) begin
          err_next   = ERR_TIMEOUT;
          state_next = ST_HUNT;
        end
      end
      ST_DONE: begin
        state_next = ST_HUNT;
      end
      default: begin
        state_next = ST_HUNT;
      end
    endcase
  end

  // Working payload buffer: one register per byte lane, written when the
  // byte counter selects it. Cleared on LEN so unused lanes read zero.
  for (genvar gi = 0; gi < BUF_BYTES; gi++) begin : g_buf
    logic [7:0] byte_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        byte_reg <= 8'd0;
      end else if (load_len) begin
        byte_reg <= 8'd0;
      end else if (store_byte && (count_reg == 3'(gi))) begin
        byte_reg <= bus.r_data;
      end
    end

    assign buf_flat[gi*8 +: 8] = byte_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_reg         <= 4'd0;
      count_reg       <= 3'd0;
      chk_reg         <= 8'd0;
      frame_valid_reg <= 1'b0;
      frame_err_reg   <= ERR_NONE;
      frame_len_reg   <= 4'd0;
      frame_data_reg  <= 64'd0;
    end else begin
      if (load_len) begin
        len_reg   <= bus.r_data[3:0];
        count_reg <= 3'd0;
        chk_reg   <= bus.r_data;
      end else if (store_byte) begin
        count_reg <= count_reg + 3'd1;
        chk_reg   <= chk_reg ^ bus.r_data;
      end
      // Registered so both pulses appear in the cycle after the deciding
      // byte; frame_valid therefore coincides with the DONE state.
      frame_valid_reg <= frame_done;
      frame_err_reg   <= err_next;
      if (frame_done) begin
        frame_len_reg  <= len_reg;
        frame_data_reg <= buf_flat;
      end
    end
  end

  assign bus.rd_uart     = pop;
  assign bus.frame_valid = frame_valid_reg;
  assign bus.frame_err   = frame_err_reg;
  assign bus.frame_len   = frame_len_reg;
  assign bus.frame_data  = frame_data_reg;

endmodule
